bcd_2of5_encoder_seq: RTL
=========================

// Module: bcd_2of5_encoder_seq
// PURPOSE
//   Parametrised sequential successor of the 4-bit combinational code converter.
//   Accepts a DIGITS-wide packed BCD word over a valid/ready handshake and encodes
//   one digit per clock into a 2-out-of-5 code word. Holds the result under
//   output backpressure. Flags non-BCD nibbles.
//   Sits between the input capture logic and the code serialiser/display path.
// PARAMETERS
//   DIGITS    4        number of BCD digits per word (>=1)
//   ERR_CODE  5'b00000 code written into the slice of any nibble > 9
// PORTS
//   clk        in   1          system clock, rising edge
//   reset      in   1          asynchronous, active-low reset
//   in_valid   in   1          in_bcd is valid
//   in_ready   out  1          block can accept a word (state==IDLE)
//   in_bcd     in   4*DIGITS   packed BCD; digit k = in_bcd[4k+3:4k], k=0 is LSD
//   out_valid  out  1          out_code/out_err hold a finished word
//   out_ready  in   1          consumer takes the word
//   out_code   out  5*DIGITS   code k = out_code[5k+4:5k]
//   out_err    out  1          at least one nibble of the word was > 9
// BEHAVIOUR
// - reset low (async, immediate):
//   - state=IDLE, digit index=0, out_valid=0, out_code=0, out_err=0, input word register=0.
//   - in_ready=1 (combinational from state); no transfer occurs while reset is low.
// - Code table (bit4..bit0), digits 0..9:
//   11000 00011 00101 00110 01001 01010 01100 10001 10010 10100.
//   Nibbles 10..15 -> ERR_CODE, and set out_err.
// - States:
//   - IDLE:
//     - in_ready=1.
//     - Edge with in_valid=1: capture in_bcd, clear out_code and out_err, idx=0, go ENCODE.
//   - ENCODE:
//     - in_ready=0, out_valid=0.
//     - Each edge writes the code for captured digit idx into slice idx; out_err |= (digit>9); idx++.
//     - On the edge that writes idx==DIGITS-1: go HOLD and set out_valid=1.
//   - HOLD:
//     - out_valid=1; out_code and out_err stable; in_ready=0.
//     - Edge with out_ready=1: out_valid=0, go IDLE. out_code/out_err keep their values until the next accept.
// - Timing:
//   - Latency: out_valid rises DIGITS edges after the accept edge.
//   - Minimum period between accepts: DIGITS+2 cycles.
// - Index counter width: max(1, $clog2(DIGITS)). DIGITS=1 must go ENCODE->HOLD after one edge.
// - Boundaries:
//   - in_valid outside IDLE is ignored; the word is not captured and not queued.
//   - in_bcd changes after the accept edge do not affect the word.
//   - out_ready outside HOLD has no effect.
//   - reset low mid-ENCODE or mid-HOLD: partial/held word discarded, outputs per reset values.
// TESTING
//   T1 DIGITS=4, in_bcd=16'h1234, out_ready=1 -> 4 edges after accept: out_valid=1, out_code=20'h194C9, out_err=0
//   T2 in_bcd=16'h9A05 -> out_code=20'b10100_00000_11000_01010, out_err=1
//   T3 word 16'h0789, out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, out_code=20'b11000_10001_10010_10100 stable,
//      in_ready=0, a second in_valid pulse is not captured
//   T4 reset low after 2 ENCODE edges -> out_valid=0, out_code=0 immediately; after release 16'h5678 encodes
//      to 20'b01010_01100_10001_10010
//   T5 in_valid held high, words 16'h1111 then 16'h2222, out_ready=1 -> accepts 6 cycles apart;
//      out_code 20'h18C63 then 20'h294A5
//   T6 DIGITS=1 build, in_bcd=4'h7 -> out_valid 1 edge after accept, out_code=5'b10001

Source files
------------

// File: rtl/bcd_2of5_encoder_seq_if.sv
// Handshake bundle carrying packed BCD words into the 2-of-5 encoder
// and finished code words out towards the serialiser/display path.
interface bcd_2of5_encoder_seq_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [5*DIGITS-1:0]   out_code;
    logic                  out_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_code, out_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_code, out_err
    );
endinterface

// File: rtl/bcd_2of5_encoder_seq.sv
// Sequential BCD to 2-out-of-5 encoder: captures a DIGITS-wide word, encodes
// one digit per clock, then holds the result until the consumer takes it.
module bcd_2of5_encoder_seq #(
    parameter int         DIGITS   = 4,
    parameter logic [4:0] ERR_CODE = 5'b00000
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_2of5_encoder_seq_if.slave bus
);
    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] word_q, word_d;
    logic [5*DIGITS-1:0] code_q, code_d;
    logic                err_q, err_d;
    logic [3:0]          digit;

    function automatic logic [4:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    return 5'b11000;
            4'd1:    return 5'b00011;
            4'd2:    return 5'b00101;
            4'd3:    return 5'b00110;
            4'd4:    return 5'b01001;
            4'd5:    return 5'b01010;
            4'd6:    return 5'b01100;
            4'd7:    return 5'b10001;
            4'd8:    return 5'b10010;
            4'd9:    return 5'b10100;
            default: return ERR_CODE;
        endcase
    endfunction

    assign digit = word_q[4*int'(idx_q) +: 4];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        code_d  = code_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_bcd;
                    code_d  = '0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                code_d[5*int'(idx_q) +: 5] = encode(digit);
                err_d = err_q | (digit > 4'd9);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset discards any partial or held word immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_code  = code_q;
    assign bus.out_err   = err_q;
endmodule
